// File: rtl/shot_sequencer_pkg.sv
// shot_pkg: shared types and constants for the shot sequencer.
//   shot_state_t - sequencer FSM states
//   SYNC_STAGES  - flip-flop depth of the asynchronous input synchronizers
package shot_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    BLANK    = 3'd2,
    FLASH    = 3'd3,
    VERDICT  = 3'd4,
    COOLDOWN = 3'd5
  } shot_state_t;

endpackage

// File: rtl/shot_sequencer_if.sv
// shot_sequencer_if: front-end inputs and renderer/game-logic outputs of the
// shot sequencer.
//   master modport - drives the front-end inputs, observes the outputs
//   slave modport  - the sequencer side
// Inputs : frame_start, gun_is_connected, gun_trigger_n, gun_photodetector,
//          mouse_left, mouse_on_target
// Outputs: blank_screen, target_flash, shot_fired, hit, miss, busy
interface shot_sequencer_if;

  logic frame_start;
  logic gun_is_connected;
  logic gun_trigger_n;
  logic gun_photodetector;
  logic mouse_left;
  logic mouse_on_target;
  logic blank_screen;
  logic target_flash;
  logic shot_fired;
  logic hit;
  logic miss;
  logic busy;

  modport master (
    output frame_start, gun_is_connected, gun_trigger_n, gun_photodetector,
           mouse_left, mouse_on_target,
    input  blank_screen, target_flash, shot_fired, hit, miss, busy
  );

  modport slave (
    input  frame_start, gun_is_connected, gun_trigger_n, gun_photodetector,
           mouse_left, mouse_on_target,
    output blank_screen, target_flash, shot_fired, hit, miss, busy
  );

endinterface

// File: rtl/shot_sequencer_sync_edge.sv
// sync_edge: SYNC_STAGES-deep synchronizer for an asynchronous input.
//   ACTIVE_LOW - input asserts low; reset loads the released (deasserted) level
//   EDGE_OUT   - 1: q is a registered one-cycle pulse on the assertion edge
//                0: q is the synchronized level, normalized to active-high
// Ports: clk, rst (async, active-high), din (async input), q (output)
module sync_edge
  import shot_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit EDGE_OUT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync_active = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  generate
    if (EDGE_OUT) begin : g_edge
      logic prev_active;
      logic edge_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prev_active <= 1'b0;
          edge_q      <= 1'b0;
        end else begin
          prev_active <= sync_active;
          edge_q      <= sync_active & ~prev_active;
        end
      end

      assign q = edge_q;
    end else begin : g_level
      assign q = sync_active;
    end
  endgenerate

endmodule

// File: rtl/shot_sequencer.sv
// shot_sequencer: sequences one light-gun or mouse shot at a time.
// Accepts a press from the selected source, blanks the screen, flashes the
// targets while sampling the photodetector (gun only), then emits exactly one
// hit or miss pulse and holds busy through a cooldown.
// Ports: clk (pixel clock), rst (async, active-high),
//        bus (shot_sequencer_if.slave: front-end inputs, renderer/game outputs)
module shot_sequencer
  import shot_pkg::*;
#(
  parameter int BLANK_FRAMES    = 1,
  parameter int FLASH_FRAMES    = 1,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int FRM_CNT_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  shot_sequencer_if.slave bus
);

  localparam logic [FRM_CNT_W-1:0] BLANK_LAST    = FRM_CNT_W'(BLANK_FRAMES - 1);
  localparam logic [FRM_CNT_W-1:0] FLASH_LAST    = FRM_CNT_W'(FLASH_FRAMES - 1);
  localparam logic [FRM_CNT_W-1:0] COOLDOWN_LAST = FRM_CNT_W'(COOLDOWN_FRAMES - 1);

  shot_state_t          state, state_next;
  logic [FRM_CNT_W-1:0] frame_cnt;
  logic                 trig_press, photo_level;
  logic                 mouse_prev, mouse_press, accept;
  logic                 src_gun, light_seen, ambient_err, mouse_hit, verdict_hit;
  logic                 shot_fired_q, blank_q, flash_q;

  sync_edge #(.ACTIVE_LOW(1'b1), .EDGE_OUT(1'b1)) u_trig_sync (
    .clk (clk),
    .rst (rst),
    .din (bus.gun_trigger_n),
    .q   (trig_press)
  );

  sync_edge #(.ACTIVE_LOW(1'b0), .EDGE_OUT(1'b0)) u_photo_sync (
    .clk (clk),
    .rst (rst),
    .din (bus.gun_photodetector),
    .q   (photo_level)
  );

  // Only the connected source may start a shot; presses while busy are dropped.
  assign mouse_press = bus.mouse_left & ~mouse_prev;
  assign accept      = (state == IDLE) &&
                       (bus.gun_is_connected ? trig_press : mouse_press);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = ARM;
      ARM:      if (bus.frame_start) state_next = src_gun ? BLANK : VERDICT;
      BLANK:    if (bus.frame_start && frame_cnt == BLANK_LAST) state_next = FLASH;
      FLASH:    if (bus.frame_start && frame_cnt == FLASH_LAST) state_next = VERDICT;
      VERDICT:  state_next = COOLDOWN;
      COOLDOWN: if (bus.frame_start && frame_cnt == COOLDOWN_LAST) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Counts whole frames inside a phase; cleared whenever the state changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      frame_cnt <= '0;
    else if (state_next != state) frame_cnt <= '0;
    else if (bus.frame_start)     frame_cnt <= frame_cnt + 1'b1;
  end

  // Source and mouse verdict are captured at acceptance; the photodetector
  // flags accumulate over every cycle of their phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mouse_prev  <= 1'b0;
      src_gun     <= 1'b0;
      light_seen  <= 1'b0;
      ambient_err <= 1'b0;
      mouse_hit   <= 1'b0;
    end else begin
      mouse_prev <= bus.mouse_left;
      if (accept) begin
        src_gun     <= bus.gun_is_connected;
        light_seen  <= 1'b0;
        ambient_err <= 1'b0;
        mouse_hit   <= ~bus.gun_is_connected & bus.mouse_on_target;
      end else begin
        if (state == BLANK && photo_level) ambient_err <= 1'b1;
        if (state == FLASH && photo_level) light_seen  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shot_fired_q <= 1'b0;
      blank_q      <= 1'b0;
      flash_q      <= 1'b0;
    end else begin
      shot_fired_q <= accept;
      blank_q      <= (state_next == BLANK);
      flash_q      <= (state_next == FLASH);
    end
  end

  assign verdict_hit      = src_gun ? (light_seen & ~ambient_err) : mouse_hit;
  assign bus.shot_fired   = shot_fired_q;
  assign bus.blank_screen = blank_q;
  assign bus.target_flash = flash_q;
  assign bus.hit          = (state == VERDICT) &  verdict_hit;
  assign bus.miss         = (state == VERDICT) & ~verdict_hit;
  assign bus.busy         = (state != IDLE);

endmodule

// File: doc/shot_sequencer.md
# shot_sequencer

Frame-synchronous controller that sequences one light-gun / mouse shot at a time. It arbitrates the shot source (gun or mouse), drives the screen-blank and target-flash phases the renderer needs, samples the photodetector in the correct frames, and emits a single hit or miss verdict. It sits between the input front-end (gun connection detector, mouse controller) and the game logic and draw pipeline.

## Interface
Parameters:
- BLANK_FRAMES, 1: frames of full-black screen before the flash.
- FLASH_FRAMES, 1: frames with the target drawn white.
- COOLDOWN_FRAMES, 8: frames after a verdict during which new shots are ignored.
- FRM_CNT_W, 4: frame counter width; must hold max(BLANK_FRAMES, FLASH_FRAMES, COOLDOWN_FRAMES).

Ports:
- clk  in  1  65 MHz pixel clock.
- rst  in  1  reset, asynchronous, active-high.
- frame_start  in  1  one-cycle pulse at the first pixel of each frame.
- gun_is_connected  in  1  level from the gun connection detector.
- gun_trigger_n  in  1  raw gun trigger, active-low, asynchronous.
- gun_photodetector  in  1  raw photodetector, high = light seen, asynchronous.
- mouse_left  in  1  mouse left button level, synchronous to clk.
- mouse_on_target  in  1  cursor-over-target level, synchronous to clk.
- blank_screen  out  1  renderer draws full black while high.
- target_flash  out  1  renderer draws target boxes white on black while high.
- shot_fired  out  1  one-cycle pulse when a shot is accepted.
- hit  out  1  one-cycle verdict pulse.
- miss  out  1  one-cycle verdict pulse.
- busy  out  1  high from acceptance until end of cooldown.

## Operation
- gun_trigger_n and gun_photodetector pass through 2-FF synchronizers; trigger press = falling edge of the synchronized trigger. Mouse press = rising edge of mouse_left.
- Source select: when gun_is_connected = 1 only gun presses are accepted; otherwise only mouse presses. Source is latched in src_gun at acceptance and held for the whole shot.
- States: IDLE, ARM, BLANK, FLASH, VERDICT, COOLDOWN.
- IDLE: on an accepted press -> ARM, pulse shot_fired, set busy. Mouse: latch mouse_on_target of the press cycle into mouse_hit.
- ARM: wait for frame_start -> BLANK (gun) or COOLDOWN via VERDICT (mouse; mouse shots skip blank/flash).
- BLANK: blank_screen = 1 for BLANK_FRAMES frames. Any synchronized photodetector high sets ambient_err.
- FLASH: target_flash = 1 for FLASH_FRAMES frames. Any synchronized photodetector high sets light_seen.
- VERDICT (one cycle): gun: hit = light_seen & ~ambient_err, else miss. Mouse: hit = mouse_hit, else miss. Exactly one of hit/miss pulses. -> COOLDOWN.
- COOLDOWN: COOLDOWN_FRAMES frame_start pulses, then -> IDLE, busy = 0. Presses during busy are dropped, never queued.
- Flags light_seen, ambient_err, mouse_hit clear on entry to ARM.
- Frame counter counts frame_start pulses, loads 0 on state entry; phase ends on the frame_start where count = N-1 (phase lasts exactly N whole frames).

## Timing
- Reset: state IDLE, all outputs 0, flags 0, synchronizers 0 except trigger sync = 1 (released).
- shot_fired: asserted the cycle after the synchronized edge (edge detector registered); gun press to shot_fired = 4 clk.
- State change to BLANK/FLASH/COOLDOWN occurs on the cycle of frame_start; blank_screen/target_flash are registered, valid from the cycle after that frame_start through the cycle of the closing frame_start.
- Photodetector sampling window: every cycle with blank_screen/target_flash high, using 2-FF-delayed samples.
- VERDICT one cycle after the FLASH closing frame_start (gun) or after the ARM frame_start (mouse).
- frame_start coincident with a press in IDLE: press accepted, frame_start ignored; ARM waits for the next one.
- gun_is_connected change mid-shot: ignored (src_gun latched). Simultaneous gun and mouse press: gun_is_connected decides.
- rst mid-shot: immediate return to IDLE, blank/flash drop asynchronously, no verdict.

## Structure
- Package shot_pkg: state enum shot_state_t, synchronizer depth constant.
- One sub-module natural: sync_edge (2-FF synchronizer + registered edge pulse, parameterized polarity), instantiated for trigger and photodetector level.

## Test plan
- Gun connected, trigger pulled, photodetector low in BLANK, pulsed high in FLASH -> shot_fired, 1 frame blank_screen, 1 frame target_flash, hit pulse, busy drops after 8 more frames.
- Gun connected, photodetector high during BLANK and FLASH -> miss (ambient_err).
- Gun disconnected, mouse_left rising with mouse_on_target = 1 -> shot_fired, no blank/flash, hit after next frame_start; repeat with 0 -> miss.
- Second trigger pull during COOLDOWN -> no shot_fired, no verdict; pull after busy = 0 -> accepted.
- Press coincident with frame_start, and gun_is_connected toggled during FLASH -> ARM waits one full frame; verdict still from gun path.
- rst asserted in FLASH -> blank_screen/target_flash/busy 0 immediately, no hit/miss ever emitted for that shot.
